snitch_icache_refill: RTL and testbench



---
 rtl/snitch_icache_pkg.sv | 45 ++++
 rtl/snitch_icache_refill_if.sv | 39 +++
 rtl/snitch_icache_refill_fifo.sv | 56 +++++
 rtl/snitch_icache_refill.sv | 90 +++++++++
 tb/tb_snitch_icache_refill.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/snitch_icache_pkg.sv
// Shared configuration and types for the snitch icache refill path.
// Widths are fixed here so the interface, the queue and the refill stage agree.
package snitch_icache_pkg;

  typedef struct packed {
    int unsigned fetch_aw;
    int unsigned line_width;
    int unsigned fill_dw;
    int unsigned pending_iw;
    int unsigned max_outstanding;
    int unsigned beats;
    int unsigned line_align;
  } config_t;

  localparam int unsigned FETCH_AW        = 32;
  localparam int unsigned LINE_WIDTH      = 128;
  localparam int unsigned FILL_DW         = 32;
  localparam int unsigned PENDING_IW      = 2;
  localparam int unsigned MAX_OUTSTANDING = 4;

  localparam int unsigned BEATS      = LINE_WIDTH / FILL_DW;
  localparam int unsigned LINE_ALIGN = $clog2(LINE_WIDTH / 8);
  localparam int unsigned BEAT_CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam config_t CFG = '{
    fetch_aw:        FETCH_AW,
    line_width:      LINE_WIDTH,
    fill_dw:         FILL_DW,
    pending_iw:      PENDING_IW,
    max_outstanding: MAX_OUTSTANDING,
    beats:           BEATS,
    line_align:      LINE_ALIGN
  };

  // Clears the byte-within-line bits so bursts always start on a line boundary.
  localparam logic [FETCH_AW-1:0] ALIGN_MASK =
    ~((FETCH_AW'(1) << LINE_ALIGN) - FETCH_AW'(1));

  typedef struct packed {
    logic [LINE_WIDTH-1:0] data;
    logic                  error;
    logic [PENDING_IW-1:0] id;
  } refill_rsp_t;

endpackage

// File: rtl/snitch_icache_refill_if.sv
// Bundle of the miss-handler side and fill-memory side handshakes of the refill stage.
// slave is the refill stage's view; master is the view of the surrounding system.
interface snitch_icache_refill_if;
  import snitch_icache_pkg::*;

  logic [FETCH_AW-1:0]   in_req_addr;
  logic [PENDING_IW-1:0] in_req_id;
  logic                  in_req_valid;
  logic                  in_req_ready;
  logic [LINE_WIDTH-1:0] in_rsp_data;
  logic                  in_rsp_error;
  logic [PENDING_IW-1:0] in_rsp_id;
  logic                  in_rsp_valid;
  logic                  in_rsp_ready;
  logic [FETCH_AW-1:0]   mem_ar_addr;
  logic [7:0]            mem_ar_len;
  logic                  mem_ar_valid;
  logic                  mem_ar_ready;
  logic [FILL_DW-1:0]    mem_r_data;
  logic                  mem_r_error;
  logic                  mem_r_last;
  logic                  mem_r_valid;
  logic                  mem_r_ready;

  modport slave (
    input  in_req_addr, in_req_id, in_req_valid, in_rsp_ready,
    input  mem_ar_ready, mem_r_data, mem_r_error, mem_r_last, mem_r_valid,
    output in_req_ready, in_rsp_data, in_rsp_error, in_rsp_id, in_rsp_valid,
    output mem_ar_addr, mem_ar_len, mem_ar_valid, mem_r_ready
  );

  modport master (
    output in_req_addr, in_req_id, in_req_valid, in_rsp_ready,
    output mem_ar_ready, mem_r_data, mem_r_error, mem_r_last, mem_r_valid,
    input  in_req_ready, in_rsp_data, in_rsp_error, in_rsp_id, in_rsp_valid,
    input  mem_ar_addr, mem_ar_len, mem_ar_valid, mem_r_ready
  );

endinterface

// File: rtl/snitch_icache_refill_fifo.sv
// Small synchronous FIFO (fifo_v3-compatible parameters) used to track refill IDs in order.
// With FALL_THROUGH set, a push into an empty FIFO is visible on data_o in the same cycle.
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, wr_ptr_q;
  logic [PTR_W:0]        cnt_q;
  logic                  stored_empty, bypass, do_push, do_pop;

  assign stored_empty = (cnt_q == '0);
  assign bypass       = FALL_THROUGH && stored_empty && push_i;
  assign full_o       = (cnt_q == FULL_CNT);
  assign empty_o      = stored_empty && !bypass;
  assign data_o       = bypass ? data_i : mem_q[rd_ptr_q];
  assign do_push      = push_i && !full_o && !(bypass && pop_i);
  assign do_pop       = pop_i && !stored_empty;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
      cnt_q <= cnt_q + (PTR_W + 1)'(do_push) - (PTR_W + 1)'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/snitch_icache_refill.sv
// Line refill stage: issues one burst per miss, assembles the returned beats into a line
// and hands it back tagged with the pending ID, which travels in an in-order queue.
module snitch_icache_refill
  import snitch_icache_pkg::*;
(
  input logic                   clk_i,
  input logic                   rst_i,
  snitch_icache_refill_if.slave bus
);

  logic                  queue_full, queue_empty, queue_push, queue_pop;
  logic [PENDING_IW-1:0] head_id;
  logic [BEAT_CW-1:0]    beat_q;
  logic [LINE_WIDTH-1:0] buffer_q, line_merged;
  logic                  error_q, out_valid_q, final_beat, beat_hs;
  refill_rsp_t           out_q;

  // A full queue blocks new bursts even when a line retires this cycle.
  assign bus.mem_ar_addr  = bus.in_req_addr & ALIGN_MASK;
  assign bus.mem_ar_len   = 8'(BEATS - 1);
  assign bus.mem_ar_valid = bus.in_req_valid & ~queue_full;
  assign bus.in_req_ready = bus.mem_ar_ready & ~queue_full;
  assign queue_push       = bus.in_req_valid & bus.in_req_ready;

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DATA_WIDTH   (PENDING_IW),
    .DEPTH        (CFG.max_outstanding)
  ) i_id_queue (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (1'b0),
    .full_o  (queue_full),
    .empty_o (queue_empty),
    .data_i  (bus.in_req_id),
    .push_i  (queue_push),
    .data_o  (head_id),
    .pop_i   (queue_pop)
  );

  // Only the final beat waits for the output register to free up.
  assign final_beat      = (beat_q == BEAT_CW'(BEATS - 1));
  assign bus.mem_r_ready = ~queue_empty & (~final_beat | ~out_valid_q | bus.in_rsp_ready);
  assign beat_hs         = bus.mem_r_valid & bus.mem_r_ready;
  assign queue_pop       = beat_hs & final_beat;

  always_comb begin
    line_merged = buffer_q;
    line_merged[beat_q*FILL_DW +: FILL_DW] = bus.mem_r_data;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      beat_q   <= '0;
      buffer_q <= '0;
      error_q  <= 1'b0;
    end else if (beat_hs) begin
      buffer_q <= line_merged;
      if (final_beat) begin
        beat_q  <= '0;
        error_q <= 1'b0;
      end else begin
        beat_q  <= beat_q + BEAT_CW'(1);
        error_q <= error_q | bus.mem_r_error;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (queue_pop) begin
      out_q       <= '{data: line_merged, error: error_q | bus.mem_r_error, id: head_id};
      out_valid_q <= 1'b1;
    end else if (bus.in_rsp_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_rsp_data  = out_q.data;
  assign bus.in_rsp_error = out_q.error;
  assign bus.in_rsp_id    = out_q.id;
  assign bus.in_rsp_valid = out_valid_q;

  // The beat counter is authoritative; the last flag must agree with it.
  assert property (@(posedge clk_i) disable iff (rst_i) beat_hs |-> (bus.mem_r_last == final_beat));
  assert property (@(posedge clk_i) disable iff (rst_i) bus.mem_r_valid |-> !queue_empty);

endmodule

// File: tb/tb_snitch_icache_refill.sv
// Directed bench for the refill stage: stimulus pushes expected bursts/lines into queues,
// a negedge monitor pops and compares whenever a handshake is presented.
module tb_snitch_icache_refill;
  import snitch_icache_pkg::*;

  typedef struct packed {
    logic [127:0] data;
    logic         error;
    logic [1:0]   id;
  } exp_rsp_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  snitch_icache_refill_if bus ();

  snitch_icache_refill dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int          n_vectors     = 0;
  int          n_miscompares = 0;
  int          cycle         = 0;
  logic [31:0] exp_ar_q [$];
  exp_rsp_t    exp_rsp_q [$];
  int          rsp_cycles [$];

  always @(posedge clk_i) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    n_vectors++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Issues one refill request and waits (bounded) for the handshake.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] exp_ar, input logic [1:0] id);
    int waited = 0;
    exp_ar_q.push_back(exp_ar);
    bus.in_req_addr  = addr;
    bus.in_req_id    = id;
    bus.in_req_valid = 1'b1;
    bus.mem_ar_ready = 1'b1;
    @(negedge clk_i);
    while (!bus.in_req_ready && waited < 100) begin
      @(negedge clk_i);
      waited++;
    end
    checkOutput("req_accept", bus.in_req_ready, 1);
    @(posedge clk_i);
    #1;
    bus.in_req_valid = 1'b0;
  endtask

  task automatic driveBeat(input logic [31:0] data, input logic err, input logic last, input bit probe_no_bypass);
    int waited = 0;
    bus.mem_r_data  = data;
    bus.mem_r_error = err;
    bus.mem_r_last  = last;
    bus.mem_r_valid = 1'b1;
    @(negedge clk_i);
    while (!bus.mem_r_ready && waited < 100) begin
      @(negedge clk_i);
      waited++;
    end
    checkOutput("beat_accept", bus.mem_r_ready, 1);
    if (probe_no_bypass) checkOutput("no_bypass_req_ready", bus.in_req_ready, 0);
    @(posedge clk_i);
    #1;
    bus.mem_r_valid = 1'b0;
    bus.mem_r_last  = 1'b0;
    bus.mem_r_error = 1'b0;
  endtask

  task automatic applyBeats(input logic [127:0] line, input logic [3:0] err, input logic [1:0] id, input bit probe_no_bypass);
    exp_rsp_q.push_back('{data: line, error: |err, id: id});
    for (int k = 0; k < 4; k++)
      driveBeat(line[k*32 +: 32], err[k], k == 3, probe_no_bypass && k == 3);
  endtask

  // Scoreboard monitor: compares every AR and response handshake against the queues.
  initial begin
    exp_rsp_t    e;
    logic [31:0] a;
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        if (bus.mem_ar_valid && bus.mem_ar_ready) begin
          if (exp_ar_q.size() == 0) checkOutput("ar_unexpected", exp_ar_q.size(), 1);
          else begin
            a = exp_ar_q.pop_front();
            checkOutput("ar_addr", bus.mem_ar_addr, a);
            checkOutput("ar_len", bus.mem_ar_len, 3);
          end
        end
        if (bus.in_rsp_valid && bus.in_rsp_ready) begin
          rsp_cycles.push_back(cycle);
          if (exp_rsp_q.size() == 0) checkOutput("rsp_unexpected", exp_rsp_q.size(), 1);
          else begin
            e = exp_rsp_q.pop_front();
            checkOutput("rsp_data", bus.in_rsp_data, e.data);
            checkOutput("rsp_error", bus.in_rsp_error, e.error);
            checkOutput("rsp_id", bus.in_rsp_id, e.id);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [127:0] line_a, line_b, line_c;

  initial begin
    bus.in_req_addr  = '0;
    bus.in_req_id    = '0;
    bus.in_req_valid = 1'b0;
    bus.in_rsp_ready = 1'b0;
    bus.mem_ar_ready = 1'b0;
    bus.mem_r_data   = '0;
    bus.mem_r_error  = 1'b0;
    bus.mem_r_last   = 1'b0;
    bus.mem_r_valid  = 1'b0;

    $display("[TB] reset state");
    @(negedge clk_i);
    checkOutput("reset_rsp_valid", bus.in_rsp_valid, 0);
    checkOutput("reset_ar_valid", bus.mem_ar_valid, 0);
    checkOutput("reset_req_ready", bus.in_req_ready, 0);
    checkOutput("reset_r_ready", bus.mem_r_ready, 0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    bus.in_rsp_ready = 1'b1;
    idle(1);

    $display("[TB] single refill");
    applyStimulus(32'h1000_0013, 32'h1000_0010, 2'd2);
    applyBeats(128'h0000000D_0000000C_0000000B_0000000A, 4'b0000, 2'd2, 1'b0);
    checkOutput("line_latency_valid", bus.in_rsp_valid, 1);
    idle(2);

    $display("[TB] error merge");
    applyStimulus(32'h2000_0044, 32'h2000_0040, 2'd1);
    applyStimulus(32'h2000_008F, 32'h2000_0080, 2'd3);
    applyBeats(128'h11111114_11111113_11111112_11111111, 4'b0010, 2'd1, 1'b0);
    applyBeats(128'h22222224_22222223_22222222_22222221, 4'b0000, 2'd3, 1'b0);
    idle(2);

    $display("[TB] outstanding limit");
    applyStimulus(32'h3000_0000, 32'h3000_0000, 2'd0);
    applyStimulus(32'h3000_0010, 32'h3000_0010, 2'd1);
    applyStimulus(32'h3000_0020, 32'h3000_0020, 2'd2);
    applyStimulus(32'h3000_0030, 32'h3000_0030, 2'd3);
    exp_ar_q.push_back(32'h3000_0040);
    bus.in_req_addr  = 32'h3000_0048;
    bus.in_req_id    = 2'd0;
    bus.in_req_valid = 1'b1;
    @(negedge clk_i);
    checkOutput("full_req_ready", bus.in_req_ready, 0);
    checkOutput("full_ar_valid", bus.mem_ar_valid, 0);
    @(posedge clk_i);
    #1;
    applyBeats(128'h30000003_30000002_30000001_30000000, 4'b0000, 2'd0, 1'b1);
    @(negedge clk_i);
    checkOutput("fifth_req_ready", bus.in_req_ready, 1);
    @(posedge clk_i);
    #1;
    bus.in_req_valid = 1'b0;
    applyBeats(128'h31000003_31000002_31000001_31000000, 4'b0000, 2'd1, 1'b0);
    applyBeats(128'h32000003_32000002_32000001_32000000, 4'b0100, 2'd2, 1'b0);
    applyBeats(128'h33000003_33000002_33000001_33000000, 4'b0000, 2'd3, 1'b0);
    applyBeats(128'h34000003_34000002_34000001_34000000, 4'b0000, 2'd0, 1'b0);

    $display("[TB] output backpressure");
    line_a = 128'hA0A0A0A3_A0A0A0A2_A0A0A0A1_A0A0A0A0;
    line_b = 128'hB0B0B0B3_B0B0B0B2_B0B0B0B1_B0B0B0B0;
    applyStimulus(32'h4000_0000, 32'h4000_0000, 2'd1);
    applyStimulus(32'h4000_0010, 32'h4000_0010, 2'd2);
    bus.in_rsp_ready = 1'b0;
    applyBeats(line_a, 4'b0000, 2'd1, 1'b0);
    exp_rsp_q.push_back('{data: line_b, error: 1'b0, id: 2'd2});
    for (int k = 0; k < 3; k++) driveBeat(line_b[k*32 +: 32], 1'b0, 1'b0, 1'b0);
    bus.mem_r_data  = line_b[127:96];
    bus.mem_r_last  = 1'b1;
    bus.mem_r_valid = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      checkOutput("stall_r_ready", bus.mem_r_ready, 0);
      checkOutput("hold_rsp_valid", bus.in_rsp_valid, 1);
      checkOutput("hold_rsp_data", bus.in_rsp_data, line_a);
    end
    @(posedge clk_i);
    #1;
    bus.in_rsp_ready = 1'b1;
    @(negedge clk_i);
    checkOutput("release_r_ready", bus.mem_r_ready, 1);
    @(posedge clk_i);
    #1;
    bus.mem_r_valid = 1'b0;
    bus.mem_r_last  = 1'b0;
    checkOutput("reload_rsp_valid", bus.in_rsp_valid, 1);
    checkOutput("reload_rsp_id", bus.in_rsp_id, 2);

    $display("[TB] back-to-back full rate");
    applyStimulus(32'h5000_0000, 32'h5000_0000, 2'd0);
    applyStimulus(32'h5000_0010, 32'h5000_0010, 2'd1);
    applyStimulus(32'h5000_0020, 32'h5000_0020, 2'd2);
    rsp_cycles.delete();
    applyBeats(128'h50000003_50000002_50000001_50000000, 4'b0000, 2'd0, 1'b0);
    applyBeats(128'h51000003_51000002_51000001_51000000, 4'b0000, 2'd1, 1'b0);
    applyBeats(128'h52000003_52000002_52000001_52000000, 4'b0000, 2'd2, 1'b0);
    idle(2);
    checkOutput("b2b_count", rsp_cycles.size(), 3);
    if (rsp_cycles.size() == 3) begin
      checkOutput("b2b_gap_0", rsp_cycles[1] - rsp_cycles[0], 4);
      checkOutput("b2b_gap_1", rsp_cycles[2] - rsp_cycles[1], 4);
    end

    $display("[TB] reset mid-burst");
    line_c = 128'hC0C0C0C3_C0C0C0C2_C0C0C0C1_C0C0C0C0;
    applyStimulus(32'h6000_0000, 32'h6000_0000, 2'd3);
    bus.in_rsp_ready = 1'b0;
    applyBeats(line_c, 4'b0000, 2'd3, 1'b0);
    applyStimulus(32'h6000_0010, 32'h6000_0010, 2'd0);
    driveBeat(32'hDEAD_0000, 1'b1, 1'b0, 1'b0);
    driveBeat(32'hDEAD_0001, 1'b0, 1'b0, 1'b0);
    bus.mem_ar_ready = 1'b0;
    rst_i = 1'b1;
    exp_rsp_q.delete();
    #1;
    checkOutput("midreset_rsp_valid", bus.in_rsp_valid, 0);
    checkOutput("midreset_rsp_data", bus.in_rsp_data, 0);
    checkOutput("midreset_r_ready", bus.mem_r_ready, 0);
    checkOutput("midreset_req_ready", bus.in_req_ready, 0);
    checkOutput("midreset_ar_valid", bus.mem_ar_valid, 0);
    idle(2);
    rst_i = 1'b0;
    bus.in_rsp_ready = 1'b1;
    idle(1);
    applyStimulus(32'h7000_0004, 32'h7000_0000, 2'd1);
    applyBeats(128'h70000003_70000002_70000001_70000000, 4'b0000, 2'd1, 1'b0);
    idle(3);

    checkOutput("rsp_queue_drained", exp_rsp_q.size(), 0);
    checkOutput("ar_queue_drained", exp_ar_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
